// File: rtl/interrupt_priority_resolver_if.sv
// Request/arbitration bundle between peripheral-side control and the priority resolver.
// master drives requests, masks and claim/complete strobes; slave is the resolver.
interface interrupt_priority_resolver_if #(
   parameter int unsigned N_interrupts = 32,
   parameter int unsigned PRIO_W       = 3
) ();
   logic [N_interrupts-1:0]        interrupt_requests;
   logic [N_interrupts-1:0]        interrupt_enables;
   logic [N_interrupts*PRIO_W-1:0] interrupt_priorities;
   logic [PRIO_W-1:0]              priority_threshold;
   logic                           interrupt_claimed;
   logic                           interrupt_complete;
   logic [31:0]                    complete_ID;
   logic [31:0]                    active_interrupt_ID;
   logic [N_interrupts-1:0]        active_interrupt;
   logic                           interrupt_processing;
   logic [N_interrupts-1:0]        interrupt_pending;
   logic                           irq_out;

   modport master (
      output interrupt_requests, interrupt_enables, interrupt_priorities, priority_threshold,
      output interrupt_claimed, interrupt_complete, complete_ID,
      input  active_interrupt_ID, active_interrupt, interrupt_processing, interrupt_pending,
      input  irq_out
   );

   modport slave (
      input  interrupt_requests, interrupt_enables, interrupt_priorities, priority_threshold,
      input  interrupt_claimed, interrupt_complete, complete_ID,
      output active_interrupt_ID, active_interrupt, interrupt_processing, interrupt_pending,
      output irq_out
   );
endinterface

// File: rtl/interrupt_priority_resolver.sv
// Interrupt gateway + priority arbiter feeding the claim/complete register.
// Define INTR_LEVEL_SENSITIVE_EN for a level-sensitive gateway; default is edge-triggered.
module interrupt_priority_resolver #(
   parameter int unsigned N_interrupts = 32,
   parameter int unsigned PRIO_W       = 3
) (
   input logic                         clk,
   input logic                         rst,
   interrupt_priority_resolver_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StArb, StNotify, StService} state_e;

   state_e                  state_q, state_d;
   logic [N_interrupts-1:0] pending_q, pending_d;
   logic [N_interrupts-1:0] onehot_q, onehot_d;
   logic [31:0]             id_q, id_d;
   logic [31:0]             svc_id_q, svc_id_d;
   logic                    proc_q, proc_d;

   logic [N_interrupts-1:0] eligible, in_svc, clr, win_onehot;
   logic [31:0]             win_id;
   logic [PRIO_W-1:0]       win_prio, prio;
   logic                    any_elig;

`ifndef INTR_LEVEL_SENSITIVE_EN
   logic [N_interrupts-1:0] prev_q;
   // Requests already high during reset must not look like fresh edges afterwards.
   logic [N_interrupts-1:0] mask_q;
`endif

   // Eligibility and winner select; strict '>' keeps ties on the lowest index.
   always_comb begin
      eligible   = '0;
      in_svc     = '0;
      win_onehot = '0;
      win_id     = '0;
      win_prio   = '0;
      prio       = '0;
      any_elig   = 1'b0;
      for (int unsigned i = 0; i < N_interrupts; i++) begin
         prio        = bus.interrupt_priorities[i*PRIO_W +: PRIO_W];
         in_svc[i]   = (state_q == StService) && (svc_id_q == 32'(i + 1));
         eligible[i] = pending_q[i] & bus.interrupt_enables[i] &
                       (prio > bus.priority_threshold) & (prio != '0);
         if (eligible[i] && (!any_elig || prio > win_prio)) begin
            any_elig      = 1'b1;
            win_prio      = prio;
            win_id        = 32'(i + 1);
            win_onehot    = '0;
            win_onehot[i] = 1'b1;
         end
      end
   end

   // Next-state: gateway, FSM and registered outputs.
   always_comb begin
      clr = (state_q == StNotify && bus.interrupt_claimed) ? onehot_q : '0;
`ifdef INTR_LEVEL_SENSITIVE_EN
      pending_d = bus.interrupt_requests & ~in_svc & ~clr;
`else
      pending_d = (pending_q | (bus.interrupt_requests & ~prev_q & ~mask_q & ~in_svc)) & ~clr;
`endif
      state_d  = state_q;
      id_d     = id_q;
      onehot_d = onehot_q;
      svc_id_d = svc_id_q;
      unique case (state_q)
         StIdle:   if (any_elig) state_d = StArb;
         StArb:    state_d = any_elig ? StNotify : StIdle;
         StNotify: begin
            if (bus.interrupt_claimed) begin
               state_d  = StService;
               svc_id_d = id_q;
            end else if (!(|(eligible & onehot_q))) begin
               state_d = StIdle;
            end
         end
         StService: begin
            if (bus.interrupt_complete && bus.complete_ID == svc_id_q) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      proc_d = (state_q == StArb) && (state_d == StNotify);
      if (proc_d) begin
         id_d     = win_id;
         onehot_d = win_onehot;
      end else if (state_d == StIdle) begin
         id_d     = '0;
         onehot_d = '0;
         svc_id_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         pending_q <= '0;
         onehot_q  <= '0;
         id_q      <= '0;
         svc_id_q  <= '0;
         proc_q    <= 1'b0;
`ifndef INTR_LEVEL_SENSITIVE_EN
         prev_q    <= '0;
         mask_q    <= bus.interrupt_requests;
`endif
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         onehot_q  <= onehot_d;
         id_q      <= id_d;
         svc_id_q  <= svc_id_d;
         proc_q    <= proc_d;
`ifndef INTR_LEVEL_SENSITIVE_EN
         prev_q    <= bus.interrupt_requests;
         mask_q    <= '0;
`endif
      end
   end

   always_comb begin
      bus.irq_out              = (state_q == StNotify);
      bus.interrupt_processing = proc_q;
      bus.active_interrupt_ID  = id_q;
      bus.active_interrupt     = onehot_q;
      bus.interrupt_pending    = pending_q;
   end

endmodule

// File: tb/tb_interrupt_priority_resolver.sv
// Bench for interrupt_priority_resolver: priority vector table plus sequences for
// claim/complete, disable-in-notify and reset corner cases, with a notification scoreboard.
module tb_interrupt_priority_resolver;
   localparam int unsigned N  = 32;
   localparam int unsigned PW = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   interrupt_priority_resolver_if #(.N_interrupts(N), .PRIO_W(PW)) bus ();
   interrupt_priority_resolver #(.N_interrupts(N), .PRIO_W(PW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_vec = 0;
   int n_err = 0;
   int exp_q[$];
   int sb_e;

   typedef struct {
      string name;
      int    a;
      int    pa;
      int    b;
      int    pb;
      bit    en_b;
      int    thr;
      int    exp_id;
   } vec_t;
   vec_t vecs[10];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic clear_inputs();
      bus.interrupt_requests   = '0;
      bus.interrupt_enables    = '0;
      bus.interrupt_priorities = '0;
      bus.priority_threshold   = '0;
      bus.interrupt_claimed    = 1'b0;
      bus.interrupt_complete   = 1'b0;
      bus.complete_ID          = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic set_prio(input int i, input int p);
      bus.interrupt_priorities[i*PW +: PW] = PW'(p);
   endtask

   task automatic pulse(input logic [31:0] m);
      bus.interrupt_requests = m;
      step();
      bus.interrupt_requests = '0;
   endtask

   // Scoreboard: every processing pulse must match the oldest expected notification.
   always @(negedge clk) begin
      if (!rst && bus.interrupt_processing === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL sb_unexpected: got ID %0d, want no notification",
                     bus.active_interrupt_ID);
         end else begin
            sb_e = exp_q.pop_front();
            check("sb_id", bus.active_interrupt_ID, sb_e);
            check("sb_onehot", bus.active_interrupt, 32'd1 << (sb_e - 1));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, want $finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] exp_oh;
      vecs[0] = '{"single",     3, 5,  3, 5, 1'b1, 0, 4};
      vecs[1] = '{"tie",        2, 4,  7, 4, 1'b1, 0, 3};
      vecs[2] = '{"higher",     2, 4,  7, 6, 1'b1, 0, 8};
      vecs[3] = '{"thr_eq",     3, 5,  3, 5, 1'b1, 5, 0};
      vecs[4] = '{"thr_below",  3, 5,  3, 5, 1'b1, 4, 4};
      vecs[5] = '{"prio_zero",  5, 0,  5, 0, 1'b1, 0, 0};
      vecs[6] = '{"tie_ends",   0, 7, 31, 7, 1'b1, 0, 1};
      vecs[7] = '{"top_src",   31, 2,  0, 1, 1'b1, 0, 32};
      vecs[8] = '{"disabled",  10, 3, 12, 7, 1'b0, 0, 11};
      vecs[9] = '{"max_prio",  30, 7, 30, 7, 1'b1, 6, 31};

      clear_inputs();
      do_reset();
      check("rst_id", bus.active_interrupt_ID, 0);
      check("rst_onehot", bus.active_interrupt, 0);
      check("rst_pending", bus.interrupt_pending, 0);
      check("rst_irq", bus.irq_out, 0);
      check("rst_proc", bus.interrupt_processing, 0);

`ifdef INTR_LEVEL_SENSITIVE_EN
      set_prio(0, 3);
      bus.interrupt_enables[0] = 1'b1;
      exp_q.push_back(1);
      bus.interrupt_requests[0] = 1'b1;
      step(); step(); step();
      check("lvl_irq", bus.irq_out, 1);
      check("lvl_id", bus.active_interrupt_ID, 1);
      bus.interrupt_claimed = 1'b1;
      step();
      bus.interrupt_claimed = 1'b0;
      check("lvl_claim_irq", bus.irq_out, 0);
      check("lvl_claim_pend", bus.interrupt_pending, 0);
      bus.interrupt_complete = 1'b1;
      bus.complete_ID = 1;
      exp_q.push_back(1);
      step();
      bus.interrupt_complete = 1'b0;
      check("lvl_done_id", bus.active_interrupt_ID, 0);
      step();
      check("lvl_repend", bus.interrupt_pending, 32'h1);
      step();
      check("lvl_arb_irq", bus.irq_out, 0);
      step();
      check("lvl_renotify_irq", bus.irq_out, 1);
      check("lvl_renotify_id", bus.active_interrupt_ID, 1);
      bus.interrupt_requests = '0;
      do_reset();
`else
      // Basic notify timing, claim, dropped edge in service, mismatched/matched completion.
      set_prio(3, 5);
      bus.interrupt_enables[3] = 1'b1;
      exp_q.push_back(4);
      pulse(32'h8);
      check("a_pend", bus.interrupt_pending, 32'h8);
      step();
      check("a_arb_irq", bus.irq_out, 0);
      step();
      check("a_irq", bus.irq_out, 1);
      check("a_proc", bus.interrupt_processing, 1);
      check("a_id", bus.active_interrupt_ID, 4);
      check("a_onehot", bus.active_interrupt, 32'h8);
      step();
      check("a_proc_once", bus.interrupt_processing, 0);
      check("a_irq_hold", bus.irq_out, 1);
      bus.interrupt_claimed = 1'b1;
      step();
      bus.interrupt_claimed = 1'b0;
      check("a_claim_irq", bus.irq_out, 0);
      check("a_claim_pend", bus.interrupt_pending, 0);
      check("a_svc_id", bus.active_interrupt_ID, 4);
      pulse(32'h8);
      step();
      check("a_svc_edge", bus.interrupt_pending, 0);
      bus.interrupt_complete = 1'b1;
      bus.complete_ID = 5;
      step();
      bus.interrupt_complete = 1'b0;
      step();
      check("a_bad_cmpl_id", bus.active_interrupt_ID, 4);
      check("a_bad_cmpl_irq", bus.irq_out, 0);
      bus.interrupt_complete = 1'b1;
      bus.complete_ID = 4;
      step();
      bus.interrupt_complete = 1'b0;
      check("a_cmpl_id", bus.active_interrupt_ID, 0);
      step(); step(); step();
      check("a_quiet", bus.irq_out, 0);

      for (int v = 0; v < 10; v++) begin
         clear_inputs();
         do_reset();
         set_prio(vecs[v].a, vecs[v].pa);
         bus.interrupt_enables[vecs[v].a] = 1'b1;
         set_prio(vecs[v].b, vecs[v].pb);
         bus.interrupt_enables[vecs[v].b] = vecs[v].en_b;
         bus.priority_threshold = PW'(vecs[v].thr);
         exp_oh = (vecs[v].exp_id == 0) ? 32'd0 : (32'd1 << (vecs[v].exp_id - 1));
         if (vecs[v].exp_id != 0) exp_q.push_back(vecs[v].exp_id);
         pulse((32'd1 << vecs[v].a) | (32'd1 << vecs[v].b));
         step(); step();
         check({"v_irq_", vecs[v].name}, bus.irq_out, (vecs[v].exp_id != 0) ? 1 : 0);
         check({"v_id_", vecs[v].name}, bus.active_interrupt_ID, vecs[v].exp_id);
         check({"v_onehot_", vecs[v].name}, bus.active_interrupt, exp_oh);
         step();
         check({"v_proc_", vecs[v].name}, bus.interrupt_processing, 0);
      end

      // Frozen winner, priority raised before re-arbitration, simultaneous claim/complete edges.
      clear_inputs();
      do_reset();
      set_prio(2, 4);
      set_prio(7, 4);
      bus.interrupt_enables = 32'h84;
      exp_q.push_back(3);
      pulse(32'h84);
      step(); step();
      check("b_id", bus.active_interrupt_ID, 3);
      set_prio(7, 6);
      bus.interrupt_claimed = 1'b1;
      step();
      bus.interrupt_claimed = 1'b0;
      check("b_pend", bus.interrupt_pending, 32'h80);
      bus.interrupt_complete = 1'b1;
      bus.complete_ID = 3;
      exp_q.push_back(8);
      step();
      bus.interrupt_complete = 1'b0;
      check("b_idle_id", bus.active_interrupt_ID, 0);
      step(); step();
      check("b_next_irq", bus.irq_out, 1);
      check("b_next_id", bus.active_interrupt_ID, 8);
      bus.interrupt_claimed = 1'b1;
      bus.interrupt_requests[7] = 1'b1;
      step();
      bus.interrupt_claimed = 1'b0;
      bus.interrupt_requests[7] = 1'b0;
      check("b_claim_edge", bus.interrupt_pending, 0);
      step();
      bus.interrupt_complete = 1'b1;
      bus.complete_ID = 8;
      bus.interrupt_requests[7] = 1'b1;
      step();
      bus.interrupt_complete = 1'b0;
      bus.interrupt_requests[7] = 1'b0;
      check("b_cmpl_edge", bus.interrupt_pending, 0);
      step(); step(); step();
      check("b_quiet", bus.irq_out, 0);

      // Disable the winner while notifying.
      clear_inputs();
      do_reset();
      set_prio(3, 5);
      bus.interrupt_enables[3] = 1'b1;
      exp_q.push_back(4);
      pulse(32'h8);
      step(); step();
      check("c_irq", bus.irq_out, 1);
      bus.interrupt_enables[3] = 1'b0;
      step();
      check("c_drop_irq", bus.irq_out, 0);
      check("c_drop_id", bus.active_interrupt_ID, 0);
      check("c_drop_onehot", bus.active_interrupt, 0);
      step(); step(); step();
      check("c_stay_idle", bus.irq_out, 0);

      // Reset while in service with the request held high through and after reset.
      clear_inputs();
      do_reset();
      set_prio(3, 5);
      bus.interrupt_enables[3] = 1'b1;
      exp_q.push_back(4);
      pulse(32'h8);
      step(); step();
      bus.interrupt_claimed = 1'b1;
      step();
      bus.interrupt_claimed = 1'b0;
      check("d_svc_id", bus.active_interrupt_ID, 4);
      bus.interrupt_requests[3] = 1'b1;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("d_rst_id", bus.active_interrupt_ID, 0);
      check("d_rst_onehot", bus.active_interrupt, 0);
      check("d_rst_irq", bus.irq_out, 0);
      check("d_rst_proc", bus.interrupt_processing, 0);
      check("d_rst_pend", bus.interrupt_pending, 0);
      repeat (5) step();
      check("d_held_irq", bus.irq_out, 0);
      check("d_held_pend", bus.interrupt_pending, 0);
      bus.interrupt_requests = '0;
`endif

      step();
      check("sb_drain", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
